// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the multiply/divide unit
package mdu_pkg;

  localparam int MDU_W    = 32;
  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_t;

  // Magnitude of a 32-bit operand; 0x80000000 wraps to itself on purpose.
  function automatic logic [MDU_W-1:0] mag32(input logic [MDU_W-1:0] v, input logic is_signed);
    mag32 = (is_signed && v[MDU_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - execute-stage to MDU request/response bundle
interface mdu_hilo_if;
  import mdu_pkg::*;

  logic             valid;
  mdu_op_t          op;
  logic [MDU_W-1:0] a;
  logic [MDU_W-1:0] b;
  logic             flush;
  logic             stall;
  logic [MDU_W-1:0] hi;
  logic [MDU_W-1:0] lo;

  modport master (output valid, op, a, b, flush, input stall, hi, lo);
  modport slave  (input valid, op, a, b, flush, output stall, hi, lo);

endinterface

// File: rtl/mdu_div.sv
// rtl/mdu_div.sv - iterative unsigned restoring divider, one quotient bit per cycle
module mdu_div
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  kill,
  input  logic [MDU_W-1:0] dividend,
  input  logic [MDU_W-1:0] divisor,
  output logic             done,
  output logic [MDU_W-1:0] quotient,
  output logic [MDU_W-1:0] remainder
);

  logic [4:0]       r_cnt;
  logic             r_busy;
  logic [MDU_W-1:0] r_q;
  logic [MDU_W-1:0] r_r;
  logic [MDU_W-1:0] r_d;
  logic [MDU_W:0]   w_shift;
  logic [MDU_W:0]   w_diff;
  logic             w_ge;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_shift   = {r_r, r_q[MDU_W-1]};
  assign w_diff    = w_shift - {1'b0, r_d};
  assign w_ge      = ~w_diff[MDU_W];
  // Outputs show the post-iteration values so the final step can be committed on its own edge.
  assign quotient  = {r_q[MDU_W-2:0], w_ge};
  assign remainder = w_ge ? w_diff[MDU_W-1:0] : w_shift[MDU_W-1:0];
  assign done      = (r_cnt == 5'd0);

  // Load operands on start, then iterate until the counter reaches zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt  <= 5'd0;
      r_busy <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
    end else if (kill) begin
      r_cnt  <= 5'd0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_q    <= dividend;
      r_r    <= '0;
      r_d    <= divisor;
      r_cnt  <= 5'(DIV_ITER - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_q <= quotient;
      r_r <= remainder;
      if (r_cnt == 5'd0) r_busy <= 1'b0;
      else               r_cnt  <= r_cnt - 5'd1;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multiply/divide unit with architectural HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  mdu_hilo_if.slave  bus
);

  mdu_state_t       r_state;
  mdu_state_t       w_next_state;
  logic [MDU_W-1:0] r_hi;
  logic [MDU_W-1:0] r_lo;
  logic [31:0]      r_pp_ll;
  logic [31:0]      r_pp_lh;
  logic [31:0]      r_pp_hl;
  logic [31:0]      r_pp_hh;
  logic             r_mneg;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dzero;

  logic             w_accept;
  logic             w_signed;
  logic             w_is_mul;
  logic             w_is_div;
  logic [MDU_W-1:0] w_a_mag;
  logic [MDU_W-1:0] w_b_mag;
  logic [63:0]      w_prod;
  logic [63:0]      w_prod_fix;
  logic             w_div_done;
  logic [MDU_W-1:0] w_quot;
  logic [MDU_W-1:0] w_rem;
  logic [MDU_W-1:0] w_quot_fix;
  logic [MDU_W-1:0] w_rem_fix;

  assign w_accept = (r_state == S_IDLE) && bus.valid && !bus.flush;
  assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_a_mag  = mag32(bus.a, w_signed);
  assign w_b_mag  = mag32(bus.b, w_signed);

  assign w_prod = {r_pp_hh, 32'b0}
                + {16'b0, r_pp_hl, 16'b0}
                + {16'b0, r_pp_lh, 16'b0}
                + {32'b0, r_pp_ll};
  assign w_prod_fix = r_mneg ? (~w_prod + 64'd1) : w_prod;

  assign w_quot_fix = r_qneg ? (~w_quot + 32'd1) : w_quot;
  assign w_rem_fix  = r_rneg ? (~w_rem + 32'd1) : w_rem;

  assign bus.stall = (w_accept && (w_is_mul || w_is_div))
                   || ((r_state == S_DIV) && !w_div_done);
  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

  mdu_div u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (w_accept && w_is_div),
    .kill      (bus.flush),
    .dividend  (w_a_mag),
    .divisor   (w_b_mag),
    .done      (w_div_done),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state: long ops leave IDLE on accept; flush always returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next_state = S_MUL;
        else if (w_accept && w_is_div) w_next_state = S_DIV;
      end
      S_MUL:  w_next_state = S_IDLE;
      S_DIV:  if (bus.flush || w_div_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture partial products and sign flags at the accept edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pp_ll <= '0;
      r_pp_lh <= '0;
      r_pp_hl <= '0;
      r_pp_hh <= '0;
      r_mneg  <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dzero <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_pp_ll <= {16'b0, w_a_mag[15:0]}  * {16'b0, w_b_mag[15:0]};
        r_pp_lh <= {16'b0, w_a_mag[15:0]}  * {16'b0, w_b_mag[31:16]};
        r_pp_hl <= {16'b0, w_a_mag[31:16]} * {16'b0, w_b_mag[15:0]};
        r_pp_hh <= {16'b0, w_a_mag[31:16]} * {16'b0, w_b_mag[31:16]};
        r_mneg  <= w_signed && (bus.a[31] ^ bus.b[31]);
      end
      if (w_is_div) begin
        r_qneg  <= w_signed && (bus.a[31] ^ bus.b[31]);
        r_rneg  <= w_signed && bus.a[31];
        r_dzero <= (bus.b == '0);
      end
    end
  end

  // HI/LO commit: MT writes at accept, products at end of MUL, quotients on the last divide step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept && (bus.op == OP_MTHI)) begin
      r_hi <= bus.a;
    end else if (w_accept && (bus.op == OP_MTLO)) begin
      r_lo <= bus.a;
    end else if ((r_state == S_MUL) && !bus.flush) begin
      r_hi <= w_prod_fix[63:32];
      r_lo <= w_prod_fix[31:0];
    end else if ((r_state == S_DIV) && w_div_done && !bus.flush && !r_dzero) begin
      r_hi <= w_rem_fix;
      r_lo <= w_quot_fix;
    end
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with architectural HI/LO registers for the execute stage of the MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute and converts signed operands to magnitudes. Performs a registered 2-cycle unsigned multiply or a 32-iteration restoring divide, applies sign fixup and commits the 64-bit result to HI/LO. Drives a stall back to the pipeline while a long operation is in flight. MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- none (width fixed at 32/64)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low; clock clk
- valid  in  1  execute holds an MDU op this cycle
- op  in  mdu_op_t (3)  NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- a  in  32  rs operand (dividend / multiplicand / MT source)
- b  in  32  rt operand (divisor / multiplier)
- flush  in  1  cancel any in-flight op; takes priority over valid
- stall  out  1  execute must hold its instruction this cycle
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- States: IDLE, MUL, DIV.
- Accept: only in IDLE with valid=1 and flush=0. Operands and op are latched at the accept edge; `a`/`b`/`op` are ignored outside IDLE.
- MTHI/MTLO: write `a` to HI/LO at the accept edge. No state change, stall=0.
- MULT/MULTU:
  - IDLE→MUL.
  - At the accept edge, register four 16×16 partial products of |a|,|b| (raw a,b for MULTU) plus the negate flag a[31]^b[31] (signed only).
  - In MUL, the sum is formed combinationally and negated (two's complement, 64-bit) if flagged.
  - {HI,LO} are written at the end of MUL; MUL→IDLE.
- DIV/DIVU:
  - IDLE→DIV. Latch magnitudes, qneg=a[31]^b[31], rneg=a[31] (signed only).
  - Run 32 restoring iterations, one quotient bit per cycle, with a 5-bit counter 31→0.
  - On the cycle with counter=0, write LO=quotient (negated if qneg) and HI=remainder (negated if rneg); DIV→IDLE.
- Divide by zero (b=0): full 33-cycle latency retained; HI/LO are left unchanged.
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0, which falls out of 32-bit wrap of the magnitude arithmetic.
- flush: state→IDLE at the next edge, HI/LO unchanged, partial results discarded. A flush in IDLE with valid=1 suppresses the accept, including MTHI/MTLO.
- NOP or valid=0: no effect.

## Timing
- Reset values: hi=0, lo=0, stall=0, state=IDLE, divider counter=0.
- stall = (IDLE & valid & ~flush & op∈{MULT,MULTU,DIV,DIVU}) | (DIV & counter≠0). stall is 0 in MUL.
- MULT/MULTU: accept in cycle T, stall=1 in T, stall=0 in T+1 (MUL). HI/LO are visible from T+2. One stall cycle; the instruction leaves execute after T+1.
- DIV/DIVU: accept in T, stall=1 in T..T+31, stall=0 in T+32. HI/LO are visible from T+33.
- A back-to-back op may be accepted in the cycle after return to IDLE. MFHI/MFLO in that cycle see the new values.
- Reset mid-operation: returns to reset values on the next edge regardless of state.
- No forwarding from an in-flight result; the stall guarantees ordering.

## Structure
- mdu_pkg:
  - mdu_op_t enum (NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO)
  - mdu_state_t enum (IDLE, MUL, DIV)
  - constants DIV_ITER=32, MDU_W=32
- Sub-module mdu_div: iterative unsigned restoring divider.
  - Ports: clk, resetn, start, kill, dividend, divisor, counter-done, quotient, remainder.
  - Sign handling and the partial-product multiplier stay in mdu_hilo.

## Test plan
- Reset: hold resetn=0 for 2 cycles → hi=0, lo=0, stall=0. Then MTHI a=0x1234 followed by MTLO a=0x5678 → hi=0x1234, lo=0x5678, stall never high.
- MULT a=0xFFFFFFFE, b=3 → stall high exactly 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → stall high 32 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 → LO=3, HI=1.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU b=0 with prior HI=0xAAAA, LO=0x5555 → stall 32 cycles, HI/LO unchanged.
- Flush:
  - flush asserted in the 10th DIV cycle → stall=0 next cycle, HI/LO unchanged; an immediate MULT 5×6 then gives LO=30, HI=0.
  - flush in the same cycle as a valid MTLO → lo unchanged.
- Reset mid-MUL and mid-DIV → hi=lo=0, stall=0, state IDLE next cycle. A subsequent MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
